// File: rtl/fpu_norm_pkg.sv
// Shared definitions for the sequential left-shift normalizer: FSM encoding
// and the parameter legality helpers.
package fpu_norm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // The largest shift level must fit inside the operand, and all levels
    // together must be able to reach every bit position.
    function automatic bit levels_ok(input int sw, input int levels);
        return (2 ** (levels - 1) < sw) && (sw <= 2 ** levels);
    endfunction

    function automatic int lvl_width(input int levels);
        return (levels > 1) ? $clog2(levels) : 1;
    endfunction

endpackage

// File: rtl/norm_shift_left_seq_if.sv
// Request/result bundle between the FPU control FSM and the normalizer.
interface norm_shift_left_seq_if
    import fpu_norm_pkg::*;
#(
    parameter int SW     = 26,
    parameter int LEVELS = 5
);
    // start_i is a request sampled only while the normalizer is idle or in
    // its done cycle; it is ignored while busy_o is high. done_o pulses for
    // exactly one cycle when Data_o/Shift_o/Zero_o take a new result, and
    // those outputs hold until the next done_o.
    logic              start_i;
    logic [SW-1:0]     Data_i;
    logic [SW-1:0]     Data_o;
    logic [LEVELS-1:0] Shift_o;
    logic              Zero_o;
    logic              busy_o;
    logic              done_o;
    state_t            dbg_state;

    modport master (
        output start_i, Data_i,
        input  Data_o, Shift_o, Zero_o, busy_o, done_o, dbg_state
    );

    modport slave (
        input  start_i, Data_i,
        output Data_o, Shift_o, Zero_o, busy_o, done_o, dbg_state
    );

endinterface

// File: rtl/norm_level_stage.sv
// One binary-search level: shifts the operand left by 2**lvl when the top
// 2**lvl bits are all zero, and reports how far it moved.
module norm_level_stage #(
    parameter int SW     = 26,
    parameter int LEVELS = 5,
    parameter int LW     = 3
) (
    input  logic [SW-1:0]     work,
    input  logic [LW-1:0]     lvl,
    output logic              zero_window,
    output logic [SW-1:0]     data,
    output logic [LEVELS-1:0] inc
);

    int win;

    always_comb begin
        win         = 32'd1 << lvl;
        zero_window = ((work >> (SW - win)) == '0);
        data        = zero_window ? (work << win) : work;
        inc         = zero_window ? LEVELS'(win) : '0;
    end

endmodule

// File: rtl/norm_shift_left_seq.sv
// Sequential mantissa normalizer: one shift level per clock, largest first,
// reporting the total left shift for the exponent path.
module norm_shift_left_seq
    import fpu_norm_pkg::*;
#(
    parameter int SW     = 26,
    parameter int LEVELS = 5
) (
    input logic                  clk,
    input logic                  rst,
    norm_shift_left_seq_if.slave bus
);

    localparam int LW = lvl_width(LEVELS);

    if (!levels_ok(SW, LEVELS)) begin : g_cfg_check
        $error("norm_shift_left_seq: SW/LEVELS combination is not legal");
    end

    state_t            state_q, state_d;
    logic [LW-1:0]     lvl_q;
    logic [SW-1:0]     work_q;
    logic [LEVELS-1:0] acc_q;
    logic [SW-1:0]     data_q;
    logic [LEVELS-1:0] shift_q;
    logic              zero_q;
    logic              accept;
    logic              in_zero;
    logic              zero_window;
    logic [SW-1:0]     stage_data;
    logic [LEVELS-1:0] stage_inc;
    logic              busy;
    logic              done;

    norm_level_stage #(
        .SW     (SW),
        .LEVELS (LEVELS),
        .LW     (LW)
    ) u_stage (
        .work        (work_q),
        .lvl         (lvl_q),
        .zero_window (zero_window),
        .data        (stage_data),
        .inc         (stage_inc)
    );

    // The done cycle accepts a new request so operations can run back to back.
    assign accept  = bus.start_i && ((state_q == IDLE) || (state_q == DONE));
    assign in_zero = (bus.Data_i == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = in_zero ? DONE : SHIFT;
            end
            SHIFT: begin
                if (lvl_q == '0) state_d = DONE;
            end
            DONE: begin
                if (accept) state_d = in_zero ? DONE : SHIFT;
                else        state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == SHIFT);
        done = (state_q == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lvl_q   <= '0;
            work_q  <= '0;
            acc_q   <= '0;
            data_q  <= '0;
            shift_q <= '0;
            zero_q  <= 1'b0;
        end else if (accept) begin
            work_q <= bus.Data_i;
            acc_q  <= '0;
            lvl_q  <= LW'(LEVELS - 1);
            // A zero operand has nothing to normalize and skips SHIFT.
            if (in_zero) begin
                data_q  <= '0;
                shift_q <= '0;
                zero_q  <= 1'b1;
            end
        end else if (state_q == SHIFT) begin
            work_q <= stage_data;
            if (zero_window) acc_q <= acc_q + stage_inc;
            lvl_q <= lvl_q - 1'b1;
            if (lvl_q == '0) begin
                data_q  <= stage_data;
                shift_q <= zero_window ? (acc_q + stage_inc) : acc_q;
                zero_q  <= 1'b0;
            end
        end
    end

    assign bus.Data_o    = data_q;
    assign bus.Shift_o   = shift_q;
    assign bus.Zero_o    = zero_q;
    assign bus.busy_o    = busy;
    assign bus.done_o    = done;
    assign bus.dbg_state = state_q;

endmodule
